// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, defaults and address helper for the fetch sequencer.
package fetch_pkg;
    typedef enum logic [2:0] {FETCH, WAIT, HOLD, DRAIN, HALTED} fetch_state_t;
    localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr & 32'h3) == 32'h0;
    endfunction
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, runs the imem req/ready/rvalid handshake and
// holds one fetched instruction for downstream, with redirect, halt and misalign handling.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_accept,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        misalign_err
);
    fetch_state_t r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n, r_instr, r_instr_pc;
    logic r_instr_valid, w_valid_n, r_misalign, r_drain_halt, w_drain_halt_n, w_latch, w_mis, w_load;

    assign w_mis  = redirect_valid && !is_word_aligned(redirect_pc);
    // A halted sequencer only honours redirects once halt has dropped
    assign w_load = redirect_valid && !w_mis && !(r_state == HALTED && halt);

    assign imem_req     = (r_state == FETCH) && !halt && !redirect_valid;
    assign imem_addr    = r_pc;
    assign pc_out       = r_pc;
    assign instr_valid  = r_instr_valid;
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign halted       = (r_state == HALTED);
    assign misalign_err = r_misalign;

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = w_load ? redirect_pc : r_pc;
        w_valid_n      = r_instr_valid && !redirect_valid;
        w_latch        = 1'b0;
        w_drain_halt_n = r_drain_halt;
        case (r_state)
            FETCH:  w_state_n = w_mis ? HALTED : redirect_valid ? FETCH : halt ? HALTED : imem_ready ? WAIT : FETCH;
            WAIT: begin
                if (redirect_valid) begin
                    w_state_n      = DRAIN;
                    w_drain_halt_n = w_mis;
                end else if (imem_rvalid) begin
                    w_state_n = HOLD;
                    w_latch   = 1'b1;
                    w_valid_n = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_state_n = w_mis ? HALTED : FETCH;
                end else if (instr_accept) begin
                    w_state_n = FETCH;
                    w_valid_n = 1'b0;
                    w_pc_n    = r_pc + PC_INC;
                end
            end
            DRAIN: begin
                // The one outstanding response is swallowed; a misaligned redirect seen
                // while draining parks the sequencer in HALTED afterwards
                w_drain_halt_n = r_drain_halt || w_mis;
                if (imem_rvalid) begin
                    w_state_n      = (r_drain_halt || w_mis) ? HALTED : FETCH;
                    w_drain_halt_n = 1'b0;
                end
            end
            HALTED: w_state_n = w_load ? FETCH : HALTED;
            default: w_state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_misalign    <= 1'b0;
            r_drain_halt  <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_pc          <= w_pc_n;
            r_instr_valid <= w_valid_n;
            r_misalign    <= r_misalign || w_mis;
            r_drain_halt  <= w_drain_halt_n;
            if (w_latch) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the RV32 datapath. Owns the fetch PC and drives a req/ready/rvalid handshake to instruction memory.
- Presents each fetched word downstream with a valid/accept handshake.
- Applies redirects (branch/jump/trap target) and halt. Replaces the free-running PC+4 counter once instruction memory becomes multi-cycle.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; must be word-aligned.
- PC_INC, 4, byte increment between sequential instructions.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch byte address; equals pc_out
- imem_ready  in  1  memory accepts request when imem_req && imem_ready
- imem_rvalid  in  1  read data valid; exactly one per accepted request, arriving 1+ cycles after acceptance
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr  out  32  fetched instruction
- instr_pc  out  32  byte address of instr
- instr_accept  in  1  downstream consumes when instr_valid && instr_accept
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc
- redirect_pc  in  32  redirect target
- halt  in  1  level; stop fetching at next request boundary
- pc_out  out  32  current fetch PC
- halted  out  1  high in HALTED state
- misalign_err  out  1  sticky; set on misaligned redirect

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state FETCH; pc_out=RESET_PC; instr_valid=0; instr=0; instr_pc=0; misalign_err=0; halted=0. imem_req rises in the first cycle after reset deasserts.
- States: FETCH, WAIT, HOLD, DRAIN, HALTED. Encoding lives in the package.
- imem_req = (state==FETCH) && !halt && !redirect_valid. This is combinational; no request is issued in a redirect or halt cycle.
- FETCH:
  - halt=1 -> HALTED.
  - Handshake -> WAIT.
  - Otherwise remain.
- WAIT: on imem_rvalid, latch instr<=imem_rdata, instr_pc<=pc_out, instr_valid<=1 -> HOLD.
- HOLD: on accept, instr_valid<=0, pc_out<=pc_out+PC_INC (modulo 2^32, wraps to 0) -> FETCH.
- Latency: request-to-instr_valid is 1 cycle after the rvalid edge. Back-to-back throughput is one instruction per 3 cycles minimum, with zero-wait memory and immediate accept.
- Redirect has priority over every other event in every state except HALTED:
  - pc_out<=redirect_pc; instr_valid<=0; any same-cycle instr_accept is ignored.
  - From FETCH (no request issued) or HOLD -> FETCH.
  - From WAIT -> DRAIN.
  - From DRAIN: stay in DRAIN and update pc_out.
- DRAIN: wait for the outstanding imem_rvalid, discard its data -> FETCH.
- HALTED:
  - imem_req=0; halted=1.
  - redirect_valid with halt=0 -> pc_out<=redirect_pc, FETCH.
  - Redirect while halt=1 is ignored.
- halt asserted in WAIT/HOLD/DRAIN: current instruction completes normally. Halt is taken at the next FETCH entry. pc_out then holds the next un-fetched address.
- Misaligned redirect (redirect_pc[1:0]!=0), any state:
  - misalign_err<=1 (sticky until reset).
  - instr_valid<=0; target is not loaded.
  - Next state HALTED, or DRAIN first if a response is outstanding. DRAIN then exits to HALTED.
- imem_rvalid outside WAIT/DRAIN is a protocol error; ignore it (assertion in bench).
- Reset mid-operation: everything returns to reset values immediately. An outstanding memory response after reset is not tracked; memory is reset by the same signal.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (FETCH, WAIT, HOLD, DRAIN, HALTED)
  - PC_INC_DEFAULT
  - RESET_PC_DEFAULT
  - helper function is_word_aligned()
- No sub-module needed. Single module holding the FSM, PC register and instruction holding register.

Test Plan:
- Reset then zero-wait memory (ready=1, rvalid 1 cycle later), accept always 1 -> instr_pc sequence 0x0, 0x4, 0x8; imem_addr never changes while imem_req && !imem_ready.
- Memory with ready delayed 2 cycles and rvalid delayed 3; accept held low 4 cycles in HOLD -> instr/instr_pc stable while instr_valid=1; pc_out advances only after accept.
- Redirect to 0x100 while in WAIT for 0x8 -> data for 0x8 is discarded (never instr_valid); next request addr=0x100; instr_pc=0x100.
- Redirect to 0x40 in the same cycle as instr_accept in HOLD -> accept ignored; next fetch 0x40, not pc+4.
- halt raised during WAIT for 0x10 -> 0x10 delivered; then halted=1, imem_req=0, pc_out=0x14. Drop halt and redirect to 0x200 -> fetch resumes at 0x200.
- Redirect to 0x102 -> misalign_err=1 sticky, halted=1, pc_out unchanged. Async reset mid-WAIT -> all outputs return to reset values without waiting for a clock edge.
